// File: rtl/program_loader.sv
// program_loader: receives a boot image over an 8N1 UART line (4-byte
// little-endian word count followed by that many little-endian words),
// writes each word into the instruction ROM write port, and holds the CPU
// in reset until the whole image is in place.
module program_loader #(
  parameter int CLKS_PER_BIT         = 868,
  parameter int ROM_ADDRESS_BITWIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            uart_rx,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                     rom_write_data,
  output logic                            cpu_reset_n,
  output logic                            loading,
  output logic                            error
);

  localparam int CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int REM_W   = ROM_ADDRESS_BITWIDTH - 1;

  localparam logic [CNT_W-1:0]                BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]                HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]                     MAX_WORDS = 32'(1) << (ROM_ADDRESS_BITWIDTH - 2);
  localparam logic [REM_W-1:0]                REM_ONE   = REM_W'(1);
  localparam logic [ROM_ADDRESS_BITWIDTH-1:0] ADDR_STEP = ROM_ADDRESS_BITWIDTH'(4);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    RECV_LEN,
    RECV_DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  // Synchronizer and edge-detect history; all idle-high.
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Receiver state.
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]       rx_bit_q,   rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid;
  logic             frame_err;

  // Loader state.
  state_t                          state_q,     state_d;
  logic [31:0]                     word_q,      word_d;
  logic [1:0]                      byte_idx_q,  byte_idx_d;
  logic [ROM_ADDRESS_BITWIDTH-1:0] addr_q,      addr_d;
  logic [REM_W-1:0]                remaining_q, remaining_d;
  logic [31:0]                     word_ins;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its predecessor held before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Receiver next state: half-bit start recheck, then mid-bit sampling.
  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_valid = rx_sync;
          frame_err  = !rx_sync;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Current assembly word with the freshly received byte dropped into its lane.
  always_comb begin
    word_ins = word_q;
    word_ins[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
  end

  // Loader state register and datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RECV_LEN;
      word_q      <= '0;
      byte_idx_q  <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  // Loader next state and status outputs.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rom_wren    = 1'b0;
    cpu_reset_n = 1'b0;
    loading     = 1'b0;
    error       = 1'b0;
    case (state_q)
      RECV_LEN: begin
        loading = 1'b1;
        if (frame_err) begin
          state_d = ERROR;
        end else if (byte_valid) begin
          word_d     = word_ins;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            if (word_ins == '0) begin
              state_d = DONE;
            end else if (word_ins > MAX_WORDS) begin
              state_d = ERROR;
            end else begin
              state_d     = RECV_DATA;
              remaining_d = word_ins[REM_W-1:0];
            end
          end
        end
      end
      RECV_DATA: begin
        loading = 1'b1;
        if (frame_err) begin
          state_d = ERROR;
        end else if (byte_valid) begin
          word_d     = word_ins;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Bytes are at least a frame apart, so this single cycle never
        // collides with a receiver event.
        loading     = 1'b1;
        rom_wren    = 1'b1;
        addr_d      = addr_q + ADDR_STEP;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q == REM_ONE) ? DONE : RECV_DATA;
      end
      DONE: begin
        cpu_reset_n = 1'b1;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_d = ERROR;
    endcase
  end

  assign rom_address    = addr_q;
  assign rom_write_data = word_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives the same UART byte stream into two loaders (a
// 10-bit and a 4-bit ROM) and compares their ROM writes and status against a
// stream-level model of the boot protocol.
module tb_program_loader;

  localparam int CPB = 4;
  localparam int W_A = 10;
  localparam int W_B = 4;

  localparam logic [2:0] ST_LOADING = 3'b010;  // {cpu_reset_n, loading, error}
  localparam logic [2:0] ST_DONE    = 3'b100;
  localparam logic [2:0] ST_ERROR   = 3'b001;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic uart_rx = 1'b1;
  int   cyc     = 0;

  logic           a_wren, a_cpu, a_loading, a_err;
  logic [W_A-1:0] a_addr;
  logic [31:0]    a_data;
  logic           b_wren, b_cpu, b_loading, b_err;
  logic [W_B-1:0] b_addr;
  logic [31:0]    b_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Captured DUT activity.
  logic [31:0] wa_addr[$];
  logic [31:0] wa_data[$];
  int          wa_cyc[$];
  int          rise_a = -1;
  logic [31:0] wb_addr[$];
  logic [31:0] wb_data[$];
  int          wb_cyc[$];
  int          rise_b = -1;

  // Stimulus description and model results.
  logic [7:0]  stim[$];
  int          stim_gap[$];
  int          end_cyc[$];
  int          bad_idx = -1;
  bit          rand_gaps = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_wbyte[$];
  logic [2:0]  exp_status;

  program_loader #(.CLKS_PER_BIT(CPB), .ROM_ADDRESS_BITWIDTH(W_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .rom_wren(a_wren), .rom_address(a_addr), .rom_write_data(a_data),
    .cpu_reset_n(a_cpu), .loading(a_loading), .error(a_err)
  );

  program_loader #(.CLKS_PER_BIT(CPB), .ROM_ADDRESS_BITWIDTH(W_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .rom_wren(b_wren), .rom_address(b_addr), .rom_write_data(b_data),
    .cpu_reset_n(b_cpu), .loading(b_loading), .error(b_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record writes and the first cycle cpu_reset_n is seen high.
  always @(negedge clk) begin
    if (reset_n && a_wren) begin
      wa_addr.push_back(32'(a_addr));
      wa_data.push_back(a_data);
      wa_cyc.push_back(cyc);
    end
    if (reset_n && b_wren) begin
      wb_addr.push_back(32'(b_addr));
      wb_data.push_back(b_data);
      wb_cyc.push_back(cyc);
    end
    if (reset_n && a_cpu && rise_a < 0) rise_a = cyc;
    if (reset_n && b_cpu && rise_b < 0) rise_b = cyc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    #2;
    check({tag, ".a_status"}, {a_wren, a_cpu, a_loading, a_err}, 4'b0010);
    check({tag, ".a_addr"}, 64'(a_addr), 64'd0);
    check({tag, ".a_data"}, 64'(a_data), 64'd0);
    check({tag, ".b_status"}, {b_wren, b_cpu, b_loading, b_err}, 4'b0010);
    repeat (3) @(posedge clk);
    #1;
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete(); rise_a = -1;
    wb_addr.delete(); wb_data.delete(); wb_cyc.delete(); rise_b = -1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    stim.delete();
    stim_gap.delete();
    bad_idx = -1;
  endtask

  task automatic add_byte(input logic [7:0] b);
    stim.push_back(b);
    stim_gap.push_back((rand_gaps && $urandom_range(0, 3) == 0) ? 1 : 0);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) add_byte(w[8*k +: 8]);
  endtask

  // Drives nbits line bits of an 8N1 frame, starting #1 after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int nbits);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream();
    end_cyc.delete();
    for (int i = 0; i < stim.size(); i++) begin
      int g = stim_gap[i];
      if (i > 0 && i - 1 == bad_idx && g == 0) g = 1;
      uart_rx = 1'b1;
      for (int k = 0; k < g * CPB; k++) begin
        @(posedge clk);
        #1;
      end
      send_frame(stim[i], (i == bad_idx) ? 1'b0 : 1'b1, 10);
      end_cyc.push_back(cyc);
    end
    uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
  endtask

  // Protocol-level expectation for a ROM of addr_bits byte-address width.
  task automatic model(input int addr_bits);
    logic [31:0] n;
    int cap;
    exp_addr.delete(); exp_data.delete(); exp_wbyte.delete();
    exp_status = ST_LOADING;
    cap = 1 << (addr_bits - 2);
    if (bad_idx >= 0 && bad_idx < 4) begin
      exp_status = ST_ERROR;
    end else if (stim.size() >= 4) begin
      n = {stim[3], stim[2], stim[1], stim[0]};
      if (n == 0) begin
        exp_status = ST_DONE;
      end else if (n > 32'(cap)) begin
        exp_status = ST_ERROR;
      end else begin
        for (int w = 0; w < int'(n); w++) begin
          int first = 4 + 4 * w;
          if (bad_idx >= first && bad_idx < first + 4) begin
            exp_status = ST_ERROR;
            break;
          end
          if (first + 3 >= stim.size()) break;
          exp_addr.push_back(32'((4 * w) % (1 << addr_bits)));
          exp_data.push_back({stim[first + 3], stim[first + 2], stim[first + 1], stim[first]});
          exp_wbyte.push_back(first + 3);
          if (w == int'(n) - 1) exp_status = ST_DONE;
        end
      end
    end
  endtask

  task automatic compare(input int which, input string name);
    logic [31:0] ga[$];
    logic [31:0] gd[$];
    int          gc[$];
    int          rise;
    int          lat;
    logic [2:0]  st;
    if (which == 0) begin
      ga = wa_addr; gd = wa_data; gc = wa_cyc; rise = rise_a;
      st = {a_cpu, a_loading, a_err};
      model(W_A);
    end else begin
      ga = wb_addr; gd = wb_data; gc = wb_cyc; rise = rise_b;
      st = {b_cpu, b_loading, b_err};
      model(W_B);
    end
    check({name, ".count"}, 64'(ga.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < ga.size(); i++) begin
      check($sformatf("%s.addr%0d", name, i), 64'(ga[i]), 64'(exp_addr[i]));
      check($sformatf("%s.data%0d", name, i), 64'(gd[i]), 64'(exp_data[i]));
      lat = gc[i] - end_cyc[exp_wbyte[i]];
      check($sformatf("%s.wr_lat%0d", name, i), 64'(lat >= 0 && lat <= 4), 64'd1);
    end
    check({name, ".status"}, 64'(st), 64'(exp_status));
    if (exp_status == ST_DONE) begin
      if (exp_addr.size() == 0) begin
        lat = rise - end_cyc[3];
        check({name, ".rise_hdr"}, 64'(lat >= 0 && lat <= 4), 64'd1);
      end else if (gc.size() > 0) begin
        check({name, ".rise"}, 64'(rise), 64'(gc[gc.size() - 1] + 1));
      end
    end else begin
      check({name, ".no_rise"}, 64'(rise), 64'(-1));
    end
  endtask

  task automatic run_case(input string name);
    send_stream();
    compare(0, {name, ".a"});
    compare(1, {name, ".b"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] n;
    int          nw;
    bit          seen;

    // Single word.
    apply_reset("rst1");
    clear_stim(); add_word(32'd1); add_word(32'h00A0_0513);
    run_case("one");

    // Three words back-to-back.
    apply_reset("rst2");
    clear_stim(); add_word(32'd3);
    add_word(32'h1111_1111); add_word(32'h2222_2222); add_word(32'h3333_3333);
    run_case("three");

    // Empty image, trailing bytes ignored.
    apply_reset("rst3");
    clear_stim(); add_word(32'd0); add_word(32'hDEAD_BEEF);
    run_case("empty");

    // Capacity boundary of the small ROM, plus oversize counts.
    apply_reset("rst4");
    clear_stim(); add_word(32'd5);
    for (int i = 0; i < 5; i++) add_word(32'hA000_0000 + 32'(i));
    run_case("n5");
    apply_reset("rst5");
    clear_stim(); add_word(32'd4);
    for (int i = 0; i < 4; i++) add_word(32'hB000_0000 + 32'(i));
    run_case("n4");
    apply_reset("rst6");
    clear_stim(); add_word(32'd257); add_word(32'h1234_5678);
    run_case("n257");
    apply_reset("rst7");
    clear_stim(); add_word(32'hFFFF_FFFF);
    run_case("nmax32");

    // Framing error on the second data byte, then recovery.
    apply_reset("rst8");
    clear_stim(); add_word(32'd2); add_word(32'h0102_0304); add_word(32'h0506_0708);
    bad_idx = 5;
    run_case("frame");
    apply_reset("rst9");
    clear_stim(); add_word(32'd1); add_word(32'hCAFE_F00D);
    run_case("recover");

    // Idle glitch is not a byte.
    apply_reset("rst10");
    uart_rx = 1'b0;
    @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    clear_stim(); add_word(32'd1); add_word(32'h0BAD_F00D);
    run_case("glitch");

    // Reset in the middle of a header frame.
    apply_reset("rst11");
    send_frame(8'h07, 1'b1, 10);
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'h00, 1'b1, 5);
    apply_reset("midhdr");
    clear_stim(); add_word(32'd2); add_word(32'h5555_AAAA); add_word(32'h0F0F_F0F0);
    run_case("after_midhdr");

    // Reset during the WRITE cycle itself.
    apply_reset("rst12");
    w0 = $urandom;
    clear_stim(); add_word(32'd2); add_word(w0);
    for (int i = 0; i < stim.size(); i++) send_frame(stim[i], 1'b1, 10);
    uart_rx = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (a_wren) seen = 1'b1;
    end
    check("midwr.seen", 64'(seen), 64'd1);
    check("midwr.data", 64'(a_data), 64'(w0));
    apply_reset("midwr");
    clear_stim(); add_word(32'd1); add_word(32'h7777_1234);
    run_case("after_midwr");

    // Randomized images.
    rand_gaps = 1'b1;
    for (int it = 0; it < 20; it++) begin
      apply_reset($sformatf("rrst%0d", it));
      clear_stim();
      if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(257, 5000));
      else n = 32'($urandom_range(0, 6));
      add_word(n);
      nw = (n > 6) ? $urandom_range(0, 1) : int'(n);
      if (nw > 0 && $urandom_range(0, 4) == 0) nw--;
      for (int w = 0; w < nw; w++) add_word($urandom);
      if ($urandom_range(0, 3) == 0) add_byte(8'($urandom));
      if ($urandom_range(0, 5) == 0) bad_idx = $urandom_range(0, stim.size() - 1);
      run_case($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
